// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit order, the sixteen hex glyphs
// and the scan-reader FSM state type.
package seg7_pkg;

   localparam int SEG_DP_IDX = 7;
   localparam int SEG_A_IDX  = 6;

   // {a,b,c,d,e,f,g}, a in bit 6
   localparam logic [6:0] GLYPH_0 = 7'h7E;
   localparam logic [6:0] GLYPH_1 = 7'h30;
   localparam logic [6:0] GLYPH_2 = 7'h6D;
   localparam logic [6:0] GLYPH_3 = 7'h79;
   localparam logic [6:0] GLYPH_4 = 7'h33;
   localparam logic [6:0] GLYPH_5 = 7'h5B;
   localparam logic [6:0] GLYPH_6 = 7'h5F;
   localparam logic [6:0] GLYPH_7 = 7'h70;
   localparam logic [6:0] GLYPH_8 = 7'h7F;
   localparam logic [6:0] GLYPH_9 = 7'h7B;
   localparam logic [6:0] GLYPH_A = 7'h77;
   localparam logic [6:0] GLYPH_B = 7'h1F;
   localparam logic [6:0] GLYPH_C = 7'h4E;
   localparam logic [6:0] GLYPH_D = 7'h3D;
   localparam logic [6:0] GLYPH_E = 7'h4F;
   localparam logic [6:0] GLYPH_F = 7'h47;

   typedef enum logic {
      SETTLE = 1'b0,
      HOLD   = 1'b1
   } scan_state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex glyph table: a 7-segment pattern maps back
// to its hex value; anything that is not one of the sixteen glyphs is invalid.
module seg7_pattern_decode
   import seg7_pkg::*;
(
   input  logic [6:0] i_pattern,
   output logic [3:0] o_value,
   output logic       o_valid
);

   always_comb begin
      // NOTE: both outputs get a default before the case so no path can infer a latch.
      o_value = 4'h0;
      o_valid = 1'b1;
      case (i_pattern)
         GLYPH_0: o_value = 4'h0;
         GLYPH_1: o_value = 4'h1;
         GLYPH_2: o_value = 4'h2;
         GLYPH_3: o_value = 4'h3;
         GLYPH_4: o_value = 4'h4;
         GLYPH_5: o_value = 4'h5;
         GLYPH_6: o_value = 4'h6;
         GLYPH_7: o_value = 4'h7;
         GLYPH_8: o_value = 4'h8;
         GLYPH_9: o_value = 4'h9;
         GLYPH_A: o_value = 4'hA;
         GLYPH_B: o_value = 4'hB;
         GLYPH_C: o_value = 4'hC;
         GLYPH_D: o_value = 4'hD;
         GLYPH_E: o_value = 4'hE;
         GLYPH_F: o_value = 4'hF;
         default: o_valid = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg7_scan_reader.sv
// Watches a multiplexed 7-segment bus, captures each settled dwell once, and
// publishes a coherent frame of decoded digits when every digit has been seen.
module seg7_scan_reader
   import seg7_pkg::*;
#(
   parameter int DIGITS     = 4,
   parameter int STABLE_CYC = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DIGITS-1:0]     dig_en,
   input  logic [7:0]            seg_in,
   output logic [4*DIGITS-1:0]   digits_out,
   output logic [DIGITS-1:0]     dp_out,
   output logic [DIGITS-1:0]     err_out,
   output logic                  frame_valid,
   output logic                  onehot_err
);

   localparam int              CNT_W   = $clog2(STABLE_CYC);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYC - 1);

   logic [DIGITS-1:0]   r_en;
   logic [7:0]          r_seg;
   logic [CNT_W-1:0]    r_cnt;
   scan_state_t         r_state;
   logic [3:0]          r_work_val [DIGITS];
   logic [DIGITS-1:0]   r_work_dp;
   logic [DIGITS-1:0]   r_work_err;
   logic [DIGITS-1:0]   r_seen;
   logic [4*DIGITS-1:0] r_digits;
   logic [DIGITS-1:0]   r_dp;
   logic [DIGITS-1:0]   r_err;
   logic                r_frame_valid;
   logic                r_onehot_err;

   logic [CNT_W-1:0]    w_cnt_next;
   scan_state_t         w_state_next;
   logic                w_same;
   logic                w_capture;
   logic                w_onehot;
   logic                w_write;
   logic                w_frame;
   logic [DIGITS-1:0]   w_seen_next;
   logic [3:0]          w_val;
   logic                w_valid;

   seg7_pattern_decode u_decode (
      .i_pattern (r_seg[SEG_A_IDX:0]),
      .o_value   (w_val),
      .o_valid   (w_valid)
   );

   assign w_same      = ({dig_en, seg_in} == {r_en, r_seg});
   assign w_onehot    = $onehot(r_en);
   assign w_write     = w_capture && w_onehot;
   assign w_seen_next = w_write ? (r_seen | r_en) : r_seen;
   assign w_frame     = w_write && (&w_seen_next);

   always_comb begin
      w_state_next = r_state;
      w_cnt_next   = r_cnt;
      w_capture    = 1'b0;
      if (!w_same) begin
         w_cnt_next = '0;
      end else if (r_cnt != CNT_MAX) begin
         w_cnt_next = r_cnt + CNT_W'(1);
      end
      case (r_state)
         // The held sample has matched for STABLE_CYC registrations: capture it,
         // even if the bus moves on at this very edge.
         SETTLE: if (r_cnt == CNT_MAX) begin
            w_capture = 1'b1;
            if (w_same) w_state_next = HOLD;
         end
         HOLD:   if (!w_same) w_state_next = SETTLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
         r_en          <= '0;
         r_seg         <= '0;
         r_cnt         <= '0;
         r_state       <= SETTLE;
         r_seen        <= '0;
         r_digits      <= '0;
         r_dp          <= '0;
         r_err         <= '0;
         r_frame_valid <= 1'b0;
         r_onehot_err  <= 1'b0;
      end else begin
         r_en          <= dig_en;
         r_seg         <= seg_in;
         r_cnt         <= w_cnt_next;
         r_state       <= w_state_next;
         r_seen        <= w_frame ? '0 : w_seen_next;
         r_frame_valid <= w_frame;
         r_onehot_err  <= w_capture && !w_onehot;
         if (w_frame) begin
            // The completing digit is taken straight from the decoder, not the working copy.
            for (int i = 0; i < DIGITS; i++) begin
               r_digits[4*i +: 4] <= r_en[i] ? w_val             : r_work_val[i];
               r_dp[i]            <= r_en[i] ? r_seg[SEG_DP_IDX] : r_work_dp[i];
               r_err[i]           <= r_en[i] ? !w_valid          : r_work_err[i];
            end
         end
      end
   end

   // NOTE: working registers carry no reset; seen is cleared instead, and no
   // frame can publish a digit whose seen bit was not set since the last clear.
   always_ff @(posedge clk) begin
      if (w_write && !rst) begin
         for (int i = 0; i < DIGITS; i++) begin
            if (r_en[i]) begin
               r_work_val[i] <= w_val;
               r_work_dp[i]  <= r_seg[SEG_DP_IDX];
               r_work_err[i] <= !w_valid;
            end
         end
      end
   end

   assign digits_out  = r_digits;
   assign dp_out      = r_dp;
   assign err_out     = r_err;
   assign frame_valid = r_frame_valid;
   assign onehot_err  = r_onehot_err;

endmodule

// File: tb/tb_seg7_scan_reader.sv
// Directed test-plan scenarios followed by random dwells, all checked every
// cycle against a dwell-level reference model of the scan reader.
module tb_seg7_scan_reader;

   localparam int DIGITS     = 4;
   localparam int STABLE_CYC = 4;

   logic                  clk;
   logic                  rst;
   logic [DIGITS-1:0]     dig_en;
   logic [7:0]            seg_in;
   logic [4*DIGITS-1:0]   digits_out;
   logic [DIGITS-1:0]     dp_out;
   logic [DIGITS-1:0]     err_out;
   logic                  frame_valid;
   logic                  onehot_err;

   seg7_scan_reader #(.DIGITS(DIGITS), .STABLE_CYC(STABLE_CYC)) dut (
      .clk         (clk),
      .rst         (rst),
      .dig_en      (dig_en),
      .seg_in      (seg_in),
      .digits_out  (digits_out),
      .dp_out      (dp_out),
      .err_out     (err_out),
      .frame_valid (frame_valid),
      .onehot_err  (onehot_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Independent glyph table, index = hex value.
   logic [6:0] glyph_tb [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                 7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

   int n_tests = 0;
   int n_fail  = 0;
   int n_fv    = 0;
   int n_oe    = 0;

   // Reference model: value currently on the bus and how many edges it has been registered.
   logic [DIGITS+7:0]   m_cur;
   int                  m_run;
   logic [3:0]          m_wval [DIGITS];
   logic [DIGITS-1:0]   m_wdp, m_werr, m_seen;
   logic [4*DIGITS-1:0] m_digits;
   logic [DIGITS-1:0]   m_dp, m_err;
   logic                m_fv, m_oe;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_capture(input logic [DIGITS+7:0] v);
      logic [DIGITS-1:0] en;
      logic [3:0]        val;
      logic              bad;
      en  = v[DIGITS+7:8];
      val = 4'h0;
      bad = 1'b1;
      for (int j = 0; j < 16; j++)
         if (glyph_tb[j] == v[6:0]) begin
            val = 4'(j);
            bad = 1'b0;
         end
      if ($countones(en) != 1) begin
         m_oe = 1'b1;
         return;
      end
      for (int i = 0; i < DIGITS; i++)
         if (en[i]) begin
            m_wval[i] = val;
            m_wdp[i]  = v[7];
            m_werr[i] = bad;
            m_seen[i] = 1'b1;
         end
      if (&m_seen) begin
         for (int i = 0; i < DIGITS; i++) m_digits[4*i +: 4] = m_wval[i];
         m_dp   = m_wdp;
         m_err  = m_werr;
         m_seen = '0;
         m_fv   = 1'b1;
      end
   endtask

   task automatic model_edge(input logic rst_v, input logic [DIGITS+7:0] in_v);
      m_fv = 1'b0;
      m_oe = 1'b0;
      if (rst_v) begin
         m_cur    = '0;
         m_run    = 1;
         m_seen   = '0;
         m_digits = '0;
         m_dp     = '0;
         m_err    = '0;
         return;
      end
      if (m_run == STABLE_CYC) model_capture(m_cur);
      if (in_v == m_cur) begin
         if (m_run <= STABLE_CYC) m_run++;
      end else begin
         m_cur = in_v;
         m_run = 1;
      end
   endtask

   task automatic step(input int n);
      for (int c = 0; c < n; c++) begin
         @(posedge clk);
         model_edge(rst, {dig_en, seg_in});
         #1;
         check("frame_valid", 32'(frame_valid), 32'(m_fv));
         check("onehot_err",  32'(onehot_err),  32'(m_oe));
         check("digits_out",  32'(digits_out),  32'(m_digits));
         check("dp_out",      32'(dp_out),      32'(m_dp));
         check("err_out",     32'(err_out),     32'(m_err));
         if (frame_valid === 1'b1) n_fv++;
         if (onehot_err === 1'b1) n_oe++;
      end
   endtask

   task automatic show(input logic [DIGITS-1:0] en, input logic [7:0] seg, input int n);
      dig_en = en;
      seg_in = seg;
      step(n);
   endtask

   initial begin
      logic [DIGITS-1:0] r_en_v;
      logic [7:0]        r_seg_v;
      rst    = 1'b1;
      dig_en = '0;
      seg_in = '0;
      m_cur  = '0;
      m_run  = 1;

      // Reset state
      step(3);
      check("reset_digits", 32'(digits_out), 32'h0);
      check("reset_flags", 32'({frame_valid, onehot_err, dp_out, err_out}), 32'h0);
      #1 rst = 1'b0;

      // Clean scan 1,2,3,4
      n_fv = 0;
      show(4'b0001, 8'h30, 6);
      show(4'b0010, 8'h6D, 6);
      show(4'b0100, 8'h79, 6);
      show(4'b1000, 8'h33, 6);
      check("clean_frames", 32'(n_fv), 32'd1);
      check("clean_digits", 32'(digits_out), 32'h4321);
      check("clean_err", 32'(err_out), 32'h0);
      check("clean_dp", 32'(dp_out), 32'h0);

      // Glitch rejection on digit 0, with distinct values elsewhere
      n_fv = 0;
      show(4'b0001, 8'h7E, 2);
      show(4'b0001, 8'h30, 6);
      show(4'b0010, 8'h7F, 6);
      show(4'b0100, 8'h7B, 6);
      show(4'b1000, 8'h77, 6);
      check("glitch_frames", 32'(n_fv), 32'd1);
      check("glitch_digits", 32'(digits_out), 32'hA981);

      // Illegal glyph with dp on digit 2
      show(4'b0001, 8'h30, 6);
      show(4'b0010, 8'h6D, 6);
      show(4'b0100, 8'h80, 6);
      show(4'b1000, 8'h33, 6);
      check("illegal_digits", 32'(digits_out), 32'h4021);
      check("illegal_err", 32'(err_out), 32'h4);
      check("illegal_dp", 32'(dp_out), 32'h4);

      // One-hot violation between partial captures
      n_fv = 0;
      n_oe = 0;
      show(4'b0001, 8'h4F, 6);
      show(4'b0010, 8'h47, 6);
      show(4'b0011, 8'h30, 6);
      check("viol_oe", 32'(n_oe), 32'd1);
      check("viol_no_frame", 32'(n_fv), 32'd0);
      show(4'b0100, 8'h5B, 6);
      show(4'b1000, 8'h7E, 6);
      check("viol_frames", 32'(n_fv), 32'd1);
      check("viol_digits", 32'(digits_out), 32'h05FE);

      // Long dwell then overwrite of digit 1
      n_fv = 0;
      show(4'b0010, 8'h5B, 20);
      show(4'b0010, 8'h5F, 6);
      show(4'b0001, 8'h7F, 6);
      show(4'b0100, 8'h77, 6);
      show(4'b1000, 8'h1F, 6);
      check("hold_frames", 32'(n_fv), 32'd1);
      check("hold_digits", 32'(digits_out), 32'hBA68);

      // Reset mid-frame
      show(4'b0001, 8'h3D, 6);
      show(4'b0010, 8'h4E, 6);
      rst = 1'b1;
      show(4'b0000, 8'h00, 2);
      check("midrst_digits", 32'(digits_out), 32'h0);
      check("midrst_flags", 32'({dp_out, err_out}), 32'h0);
      rst  = 1'b0;
      n_fv = 0;
      show(4'b0001, 8'h70, 6);
      show(4'b0010, 8'h7B, 6);
      show(4'b0100, 8'h5F, 6);
      show(4'b1000, 8'hB0, 6);
      check("midrst_frames", 32'(n_fv), 32'd1);
      check("midrst_after", 32'(digits_out), 32'h1697);
      check("midrst_dp", 32'(dp_out), 32'h8);

      // Random dwells
      for (int d = 0; d < 400; d++) begin
         if ($urandom_range(0, 9) == 0) r_en_v = 4'($urandom_range(0, 15));
         else r_en_v = 4'(1 << $urandom_range(0, 3));
         if ($urandom_range(0, 7) == 0) r_seg_v = 8'($urandom_range(0, 255));
         else r_seg_v = {1'($urandom_range(0, 1)), glyph_tb[$urandom_range(0, 15)]};
         if ($urandom_range(0, 49) == 0) rst = 1'b1;
         show(r_en_v, r_seg_v, $urandom_range(1, 8));
         rst = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
